// File: rtl/pulp_cg_pkg.sv
// pulp_cg_pkg: shared types for the asynchronous-request clock gate
package pulp_cg_pkg;
  typedef enum logic [1:0] {CG_OFF, CG_ON, CG_HOLD} cg_state_e;
endpackage

// File: rtl/pulp_clock_gating.sv
// pulp_clock_gating: latch-based glitch-free clock gate with DFT override
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic clk_en;
  // latch is transparent while clk_i is low, so the enable only changes between pulses
  always_latch
    if (!clk_i) clk_en = en_i | test_en_i;
  assign clk_o = clk_i & clk_en;
endmodule

// File: rtl/pulp_clock_gating_async_ch.sv
// pulp_clock_gating_async_ch: one channel of synchronised request, OFF/ON/HOLD FSM and clock gate
module pulp_clock_gating_async_ch
  import pulp_cg_pkg::*;
#(
  parameter int STAGES      = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_async_i,
  input  logic test_en_i,
  output logic en_ack_o,
  output logic active_o,
  output logic clk_o
);
  localparam int CW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = HOLD_CYCLES == 0 ? '0 : CW'(HOLD_CYCLES - 1);
  logic req_s;
  cg_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic en_d, act_d, en_q, act_q;
  pulp_sync #(.STAGES(STAGES)) i_sync (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .serial_i (en_async_i),
    .serial_o (req_s)
  );
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= CG_OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      act_q   <= act_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CG_OFF:  if (req_s) state_d = CG_ON;
      CG_ON:   if (!req_s) begin
                 state_d = HOLD_CYCLES == 0 ? CG_OFF : CG_HOLD;
                 cnt_d   = HOLD_LOAD;
               end
      CG_HOLD: if (req_s) state_d = CG_ON;
               else if (cnt_q == '0) state_d = CG_OFF;
               else cnt_d = cnt_q - 1'b1;
      default: state_d = CG_OFF;
    endcase
  end
  always_comb begin
    en_d  = state_q != CG_OFF;
    act_d = state_q == CG_ON;
  end
  assign en_ack_o = en_q;
  assign active_o = act_q;
  pulp_clock_gating i_cg (
    .clk_i     (clk_i),
    .en_i      (en_q),
    .test_en_i (test_en_i),
    .clk_o     (clk_o)
  );
endmodule

// File: rtl/pulp_sync.sv
// pulp_sync: multi-stage flop synchroniser for a single-bit asynchronous input
module pulp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic serial_i,
  output logic serial_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], serial_i};
  assign serial_o = sync_q[STAGES-1];
endmodule

// File: rtl/pulp_clock_gating_async_multi.sv
// pulp_clock_gating_async_multi: NUM_CH independent asynchronously requested clock gates
module pulp_clock_gating_async_multi #(
  parameter int NUM_CH      = 4,
  parameter int STAGES      = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NUM_CH-1:0] en_async_i,
  input  logic              test_en_i,
  output logic [NUM_CH-1:0] en_ack_o,
  output logic [NUM_CH-1:0] active_o,
  output logic [NUM_CH-1:0] clk_o
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulp_clock_gating_async_ch #(
      .STAGES      (STAGES),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) i_ch (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .en_async_i (en_async_i[i]),
      .test_en_i  (test_en_i),
      .en_ack_o   (en_ack_o[i]),
      .active_o   (active_o[i]),
      .clk_o      (clk_o[i])
    );
  end
endmodule

// File: tb/tb_pulp_clock_gating_async_multi.sv
// tb_pulp_clock_gating_async_multi: directed and random 4-phase traffic against a closed-form history model
module tb_pulp_clock_gating_async_multi;
  localparam int N = 4;
  localparam int S = 2;
  localparam int H = 4;
  logic clk_i = 1'b0, rstn_i = 1'b0, test_en_i = 1'b0;
  logic [N-1:0] en_async_i = '0;
  logic [N-1:0] ack_a, act_a, clko_a, ack_b, act_b, clko_b;
  int total = 0, bad = 0, k = 0;
  logic [N-1:0] hist [0:8191];

  always #5 clk_i = ~clk_i;

  pulp_clock_gating_async_multi #(.NUM_CH(N), .STAGES(S), .HOLD_CYCLES(H)) dut_a (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_async_i(en_async_i), .test_en_i(test_en_i),
    .en_ack_o(ack_a), .active_o(act_a), .clk_o(clko_a));
  pulp_clock_gating_async_multi #(.NUM_CH(N), .STAGES(S), .HOLD_CYCLES(0)) dut_b (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_async_i(en_async_i), .test_en_i(test_en_i),
    .en_ack_o(ack_b), .active_o(act_b), .clk_o(clko_b));

  // request value seen at edge j since reset release; nothing before release
  function automatic logic [N-1:0] r(int j);
    return j < 0 ? '0 : hist[j];
  endfunction
  // active after edge kk follows the request S+1 edges earlier; ack stretches it by h edges
  function automatic logic [N-1:0] act_m(int kk);
    return r(kk - S - 1);
  endfunction
  function automatic logic [N-1:0] ack_m(int kk, int h);
    logic [N-1:0] a = '0;
    for (int i = 0; i <= h; i++) a |= r(kk - S - 1 - i);
    return a;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    hist[k] = en_async_i;
    #2;
    check("ack_h4", ack_a, ack_m(k, H));
    check("act_h4", act_a, act_m(k));
    check("clk_hi_h4", clko_a, {N{test_en_i}} | ack_m(k - 1, H));
    check("ack_h0", ack_b, ack_m(k, 0));
    check("act_h0", act_b, act_m(k));
    check("clk_hi_h0", clko_b, {N{test_en_i}} | ack_m(k - 1, 0));
    @(negedge clk_i);
    #1;
    check("clk_lo_h4", clko_a, '0);
    check("clk_lo_h0", clko_b, '0);
    k++;
  endtask

  task automatic check_reset(input logic [N-1:0] clk_exp);
    check("rst_ack_h4", ack_a, '0);
    check("rst_act_h4", act_a, '0);
    check("rst_clk_h4", clko_a, clk_exp);
    check("rst_ack_h0", ack_b, '0);
    check("rst_act_h0", act_b, '0);
    check("rst_clk_h0", clko_b, clk_exp);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    #1;
    check_reset('0);
    rstn_i = 1'b1;
    k = 0;
    en_async_i = 4'b0001;
    repeat (13) tick();
    en_async_i = 4'b0000;
    repeat (12) tick();
    en_async_i = 4'b0001;
    repeat (15) tick();
    en_async_i = 4'b0000;
    repeat (5) tick();
    en_async_i = 4'b0001;
    repeat (10) tick();
    en_async_i = 4'b0000;
    repeat (5) tick();
    rstn_i = 1'b0;
    #1;
    check_reset('0);
    en_async_i = 4'b0001;
    test_en_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i);
      #2;
      check_reset({N{1'b1}});
      @(negedge clk_i);
      #1;
      check_reset('0);
    end
    test_en_i = 1'b0;
    rstn_i = 1'b1;
    k = 0;
    repeat (8) tick();
    en_async_i = 4'b0000;
    repeat (10) tick();
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < N; ch++)
        if (en_async_i[ch] == ack_a[ch] && $urandom_range(0, 3) == 0) en_async_i[ch] = ~en_async_i[ch];
      if ($urandom_range(0, 15) == 0) test_en_i = ~test_en_i;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
